// File: rtl/direct_mapped_cache.sv
// Eight-line direct-mapped, write-through cache sitting between the CPU datapath and Main_Memory.
// Read hits are served locally; read misses fill the indexed line, writes always go through to memory.
module direct_mapped_cache #(
    parameter int LINES = 8,
    parameter int AW    = 13,
    parameter int DW    = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_dataIn,
    input  logic          cpu_read,
    input  logic          cpu_write,
    input  logic          cpu_instruction,
    output logic [DW-1:0] cpu_dataOut,
    output logic          cpu_done,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_dataIn,
    input  logic [DW-1:0] mem_dataOut,
    output logic          mem_write,
    output logic          mem_read,
    output logic          mem_instruction,
    input  logic          mem_done,
    output logic [7:0]    hit_count,
    output logic [7:0]    miss_count
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AW - IW;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MISS_RD = 2'd1;
    localparam logic [1:0] S_WR      = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] cpu_dataOut_q, cpu_dataOut_d;
    logic          cpu_done_q, cpu_done_d;
    logic [AW-1:0] mem_address_q, mem_address_d;
    logic [DW-1:0] mem_dataIn_q, mem_dataIn_d;
    logic          mem_instruction_q, mem_instruction_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [7:0]    hit_q, hit_d;
    logic [7:0]    miss_q, miss_d;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_q  [LINES];
    logic [DW-1:0]    data_q [LINES];

    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic          req_hit;
    logic [IW-1:0] lat_idx;
    logic [TW-1:0] lat_tag;
    logic          lat_hit;
    logic          fill_en;
    logic          upd_en;
    logic [LINES-1:0] fill_line;
    logic [LINES-1:0] upd_line;

    assign req_idx = cpu_address[IW-1:0];
    assign req_tag = cpu_address[AW-1:IW];
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // The write-hit test uses the latched address: the line cannot change while WR is outstanding.
    assign lat_idx = mem_address_q[IW-1:0];
    assign lat_tag = mem_address_q[AW-1:IW];
    assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

    assign fill_en = (state_q == S_MISS_RD) && mem_done;
    assign upd_en  = (state_q == S_WR) && mem_done && lat_hit;

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line_en
            assign fill_line[gi] = fill_en && (lat_idx == IW'(gi));
            assign upd_line[gi]  = upd_en  && (lat_idx == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                if (fill_line[i]) begin
                    valid_q[i] <= 1'b1;
                    tag_q[i]   <= lat_tag;
                    data_q[i]  <= mem_dataOut;
                end else if (upd_line[i]) begin
                    data_q[i]  <= mem_dataIn_q;
                end
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        cpu_dataOut_d     = cpu_dataOut_q;
        cpu_done_d        = 1'b0;
        mem_address_d     = mem_address_q;
        mem_dataIn_d      = mem_dataIn_q;
        mem_instruction_d = mem_instruction_q;
        mem_read_d        = mem_read_q;
        mem_write_d       = mem_write_q;
        hit_d             = hit_q;
        miss_d            = miss_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_write || cpu_read) begin
                    mem_address_d     = cpu_address;
                    mem_dataIn_d      = cpu_dataIn;
                    mem_instruction_d = cpu_instruction;
                    if (cpu_write) begin
                        state_d     = S_WR;
                        mem_write_d = 1'b1;
                    end else if (req_hit) begin
                        state_d       = S_RESP;
                        cpu_done_d    = 1'b1;
                        cpu_dataOut_d = data_q[req_idx];
                        if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
                    end else begin
                        state_d    = S_MISS_RD;
                        mem_read_d = 1'b1;
                        if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
                    end
                end
            end
            S_MISS_RD: begin
                if (mem_done) begin
                    state_d       = S_RESP;
                    mem_read_d    = 1'b0;
                    cpu_dataOut_d = mem_dataOut;
                    cpu_done_d    = 1'b1;
                end
            end
            S_WR: begin
                if (mem_done) begin
                    state_d     = S_RESP;
                    mem_write_d = 1'b0;
                    cpu_done_d  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= S_IDLE;
            cpu_dataOut_q     <= '0;
            cpu_done_q        <= 1'b0;
            mem_address_q     <= '0;
            mem_dataIn_q      <= '0;
            mem_instruction_q <= 1'b0;
            mem_read_q        <= 1'b0;
            mem_write_q       <= 1'b0;
            hit_q             <= '0;
            miss_q            <= '0;
        end else begin
            state_q           <= state_d;
            cpu_dataOut_q     <= cpu_dataOut_d;
            cpu_done_q        <= cpu_done_d;
            mem_address_q     <= mem_address_d;
            mem_dataIn_q      <= mem_dataIn_d;
            mem_instruction_q <= mem_instruction_d;
            mem_read_q        <= mem_read_d;
            mem_write_q       <= mem_write_d;
            hit_q             <= hit_d;
            miss_q            <= miss_d;
        end
    end

    assign cpu_dataOut     = cpu_dataOut_q;
    assign cpu_done        = cpu_done_q;
    assign mem_address     = mem_address_q;
    assign mem_dataIn      = mem_dataIn_q;
    assign mem_instruction = mem_instruction_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign hit_count       = hit_q;
    assign miss_count      = miss_q;

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Scoreboard bench for direct_mapped_cache: a memory responder, a reference cache model
// built from address-mod-8 arithmetic, and a monitor that checks every cpu_done.
module tb_direct_mapped_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] cpu_address = '0;
    logic [12:0] cpu_dataIn = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic        cpu_instruction = 1'b0;
    logic [12:0] cpu_dataOut;
    logic        cpu_done;
    logic [12:0] mem_address;
    logic [12:0] mem_dataIn;
    logic [12:0] mem_dataOut = '0;
    logic        mem_write;
    logic        mem_read;
    logic        mem_instruction;
    logic        mem_done = 1'b0;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    always #5 clk = ~clk;

    direct_mapped_cache dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_dataIn(cpu_dataIn),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_instruction(cpu_instruction),
        .cpu_dataOut(cpu_dataOut), .cpu_done(cpu_done),
        .mem_address(mem_address), .mem_dataIn(mem_dataIn),
        .mem_dataOut(mem_dataOut), .mem_write(mem_write),
        .mem_read(mem_read), .mem_instruction(mem_instruction),
        .mem_done(mem_done), .hit_count(hit_count), .miss_count(miss_count)
    );

    typedef struct {
        bit          is_wr;
        logic [12:0] addr;
        logic [12:0] wdata;
        logic [12:0] rdata;
        bit          instr;
        int          op;      // 0 no memory access, 1 read, 2 write
        int          hits;
        int          misses;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_pass = 0;

    logic [12:0] mem_model [8192];
    logic [12:0] ref_mem   [8192];
    bit          ref_valid [8];
    int          ref_tag   [8];
    logic [12:0] ref_data  [8];
    int          ref_hits = 0;
    int          ref_misses = 0;

    int resp_delay = 1;
    bit inject_done = 1'b0;
    int last_op = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_hits = 0;
        ref_misses = 0;
    endtask

    // Main_Memory stand-in: answers after resp_delay cycles of request.
    initial begin
        int cnt = 0;
        bit busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                busy = 1'b0;
                cnt = 0;
                mem_done = inject_done;
            end else if (mem_done) begin
                mem_done = 1'b0;
                busy = 1'b0;
                chk("req_drop", {30'd0, mem_read, mem_write}, 0);
            end else begin
                if (!busy && (mem_read || mem_write)) begin
                    busy = 1'b1;
                    cnt = 0;
                    last_op = mem_write ? 2 : 1;
                    chk("rd_wr_excl", {31'd0, mem_read && mem_write}, 0);
                    if (sb.size() > 0) begin
                        chk("mem_address", mem_address, sb[0].addr);
                        chk("mem_instruction", mem_instruction, sb[0].instr);
                        if (sb[0].is_wr) chk("mem_dataIn", mem_dataIn, sb[0].wdata);
                    end
                end
                if (busy) begin
                    cnt++;
                    if (cnt == resp_delay) begin
                        chk("req_held", (last_op == 2) ? mem_write : mem_read, 1);
                        mem_dataOut = mem_model[mem_address];
                        if (mem_write) mem_model[mem_address] = mem_dataIn;
                        mem_done = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: every completion is matched against the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && cpu_done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (!e.is_wr) chk("cpu_dataOut", cpu_dataOut, e.rdata);
                    chk("hit_count", hit_count, e.hits);
                    chk("miss_count", miss_count, e.misses);
                    chk("mem_op", last_op, e.op);
                    $display("txn %s addr=%0d data=%0h op=%0d hits=%0d misses=%0d",
                             e.is_wr ? "WR" : "RD", e.addr, e.is_wr ? e.wdata : cpu_dataOut,
                             last_op, hit_count, miss_count);
                    last_op = 0;
                end
            end
        end
    end

    task automatic do_access(input bit rd, input bit wr, input logic [12:0] addr,
                             input logic [12:0] d, input bit instr, input int delay);
        exp_t e;
        int line = int'(addr) % 8;
        int tag = int'(addr) / 8;
        bit hit = ref_valid[line] && (ref_tag[line] == tag);
        int exp_lat;
        int cyc = 0;
        bit got = 1'b0;
        e.is_wr = wr;
        e.addr = addr;
        e.wdata = d;
        e.instr = instr;
        e.rdata = '0;
        if (wr) begin
            ref_mem[addr] = d;
            if (hit) ref_data[line] = d;
            e.op = 2;
            exp_lat = delay + 1;
        end else if (hit) begin
            ref_hits = (ref_hits < 255) ? ref_hits + 1 : 255;
            e.rdata = ref_data[line];
            e.op = 0;
            exp_lat = 1;
        end else begin
            ref_misses = (ref_misses < 255) ? ref_misses + 1 : 255;
            ref_valid[line] = 1'b1;
            ref_tag[line] = tag;
            ref_data[line] = ref_mem[addr];
            e.rdata = ref_mem[addr];
            e.op = 1;
            exp_lat = delay + 1;
        end
        e.hits = ref_hits;
        e.misses = ref_misses;
        sb.push_back(e);
        resp_delay = delay;
        cpu_address = addr;
        cpu_dataIn = d;
        cpu_instruction = instr;
        cpu_read = rd;
        cpu_write = wr;
        while (!got && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (cpu_done === 1'b1) got = 1'b1;
        end
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        if (!got) begin
            chk("done_timeout", 0, 1);
            finish_run();
        end
        chk("latency", cyc, exp_lat);
        @(negedge clk);
        chk("done_pulse", {31'd0, cpu_done}, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem_model[i] = 13'($urandom_range(0, 8191));
            ref_mem[i] = mem_model[i];
        end
        mem_model[5] = 13'h0F0F;
        ref_mem[5] = 13'h0F0F;
        ref_reset();

        reset = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_cpu_done", {31'd0, cpu_done}, 0);
        chk("rst_mem_read", {31'd0, mem_read}, 0);
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        chk("rst_cpu_dataOut", cpu_dataOut, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_dataIn", mem_dataIn, 0);
        chk("rst_mem_instruction", {31'd0, mem_instruction}, 0);
        chk("rst_hit_count", hit_count, 0);
        chk("rst_miss_count", miss_count, 0);

        do_access(1, 0, 13'd5, 13'd0, 0, 3);
        do_access(1, 0, 13'd5, 13'd0, 0, 2);
        do_access(0, 1, 13'd5, 13'h1234, 0, 2);
        do_access(1, 0, 13'd5, 13'd0, 1, 2);
        do_access(1, 0, 13'd13, 13'd0, 0, 1);
        do_access(1, 0, 13'd5, 13'd0, 0, 4);
        chk("evict_miss_count", miss_count, 3);
        do_access(1, 1, 13'd2, 13'h0ABC, 0, 2);
        do_access(1, 0, 13'd2, 13'd0, 0, 1);

        for (int n = 0; n < 150; n++) begin
            int r = $urandom_range(0, 3);
            logic [12:0] a = 13'($urandom_range(0, 31));
            logic [12:0] d = 13'($urandom_range(0, 8191));
            bit ins = 1'($urandom_range(0, 1));
            int dl = $urandom_range(1, 4);
            if (r == 0)      do_access(0, 1, a, d, ins, dl);
            else if (r == 1) do_access(1, 1, a, d, ins, dl);
            else             do_access(1, 0, a, d, ins, dl);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset lands mid-miss; a mem_done is presented while reset is low.
        resp_delay = 20;
        cpu_address = 13'd8000;
        cpu_read = 1'b1;
        repeat (3) @(negedge clk);
        chk("miss_pending", {31'd0, mem_read}, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_mem_read", {31'd0, mem_read}, 0);
        chk("async_mem_write", {31'd0, mem_write}, 0);
        cpu_read = 1'b0;
        inject_done = 1'b1;
        repeat (3) @(negedge clk);
        inject_done = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        last_op = 0;
        ref_reset();
        @(negedge clk);
        chk("post_rst_hit_count", hit_count, 0);
        chk("post_rst_miss_count", miss_count, 0);
        chk("post_rst_mem_read", {31'd0, mem_read}, 0);
        do_access(1, 0, 13'd5, 13'd0, 0, 2);
        do_access(1, 0, 13'd2, 13'd0, 0, 1);

        for (int n = 0; n < 300; n++) do_access(1, 0, 13'd5, 13'd0, 0, 1);
        chk("hit_saturate", hit_count, 8'hFF);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        finish_run();
    end

endmodule

// File: doc/direct_mapped_cache.md
# direct_mapped_cache

Eight-line, direct-mapped, write-through unified cache between the CPU datapath (Control/Decoder side) and Main_Memory. It accepts 13-bit word accesses from the CPU, serves read hits from its own line storage, and forwards read misses and all writes to Main_Memory over Main_Memory's address/dataIn/dataOut/write/read/instruction/Done interface. Line index is the address modulo 8, matching the existing `modulo` helper. Saturating hit and miss counters support performance checks.

## Interface
Parameters:
- `LINES`, 8: number of lines; index = address mod LINES; fixed power of two.
- `AW`, 13: address width.
- `DW`, 13: data word width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_address`  in  13  word address of the CPU access.
- `cpu_dataIn`  in  13  CPU write data.
- `cpu_read`  in  1  read request, level, held until `cpu_done`.
- `cpu_write`  in  1  write request, level, held until `cpu_done`.
- `cpu_instruction`  in  1  access is an instruction fetch; forwarded to memory.
- `cpu_dataOut`  out  13  read data, valid while `cpu_done` is high.
- `cpu_done`  out  1  one-cycle completion pulse.
- `mem_address`  out  13  address to Main_Memory.
- `mem_dataIn`  out  13  write data to Main_Memory.
- `mem_dataOut`  in  13  read data from Main_Memory.
- `mem_write`  out  1  memory write request.
- `mem_read`  out  1  memory read request.
- `mem_instruction`  out  1  registered copy of `cpu_instruction`.
- `mem_done`  in  1  memory completion, sampled on rising edge.
- `hit_count`  out  8  saturating read-hit count.
- `miss_count`  out  8  saturating read-miss count.

## Operation
- Address split: index = `cpu_address[2:0]`, tag = `cpu_address[12:3]` (10 bits). Each line holds a valid bit, a 10-bit tag and a 13-bit word.
- FSM states:
  - IDLE: samples requests.
  - MISS_RD: memory read is outstanding.
  - WR: memory write is outstanding.
  - RESP: asserts `cpu_done`.
- Transitions from IDLE:
  - `cpu_write` high → WR. Write has priority over a simultaneous read.
  - `cpu_read` high with a hit → RESP. Increment `hit_count`.
  - `cpu_read` high with a miss → MISS_RD. Increment `miss_count`.
- Request latching: on leaving IDLE, the cache registers `mem_address`, `mem_dataIn` and `mem_instruction`. CPU inputs are ignored until the cache returns to IDLE.
- MISS_RD:
  - `mem_read` is held high until `mem_done` is sampled high.
  - At that edge the line at the index gets valid=1, the new tag and `mem_dataOut`. `cpu_dataOut` is loaded with `mem_dataOut`, and the FSM moves to RESP.
  - Any previous line contents are evicted silently. No dirty state exists because the cache is write-through.
- WR:
  - `mem_write` is held high until `mem_done` is sampled high.
  - At that edge, if the line hits, its word is updated with the latched write data. A write miss does not allocate. The FSM then moves to RESP.
- RESP: `cpu_done` is high for exactly one cycle, then the FSM returns to IDLE. A request still held high at that point starts a new access.
- Counters saturate at 8'hFF. Writes do not count.
- Line storage uses flops. No flush port exists; reset is the only invalidate.

## Timing
- Reset values, with state IDLE:
  - All valid bits are 0.
  - `cpu_done`, `mem_read` and `mem_write` are 0.
  - `cpu_dataOut`, `mem_address`, `mem_dataIn` and `mem_instruction` are 0.
  - Both counters are 0.
- All outputs are registered.
- Read hit: request sampled at edge N; `cpu_done` and `cpu_dataOut` are valid in cycle N+1. Latency is 1.
- Read miss:
  - `mem_read` rises after edge N.
  - If `mem_done` is first sampled high at edge M, `mem_read` drops after M, and `cpu_done` is high in cycle M+1.
- Write: same as a read miss, using `mem_write`.
- `mem_read` and `mem_write` are never high together.
- Reset asserted mid-miss or mid-write:
  - Takes effect immediately, with no clock needed.
  - Requests drop, and no line is filled or updated.
  - A `mem_done` arriving while reset is low is ignored.

## Test plan
- Cold read of address 5, with memory returning 13'h0F0F and `mem_done` three cycles after `mem_read` rises:
  - `mem_read` is high for three cycles.
  - `cpu_done` pulses with `cpu_dataOut` = 13'h0F0F.
  - `miss_count` = 1.
- Read of address 5 again → `cpu_done` one cycle after the request, data 13'h0F0F, no `mem_read`, `hit_count` = 1.
- Write 13'h1234 to address 5:
  - `mem_write` is high with `mem_address` = 5 and `mem_dataIn` = 13'h1234.
  - After `cpu_done`, a read of address 5 hits and returns 13'h1234.
- Read of address 13 (index 5, tag 1) → miss. Then a read of address 5 → miss again (eviction). `miss_count` = 3.
- `cpu_read` and `cpu_write` both high at address 2 → only `mem_write` is issued. Write miss, no allocation. A following read of 2 misses.
- Reset pulled low during an outstanding miss:
  - `mem_read` drops without a clock edge.
  - After release, all lines are invalid and the counters are 0.
- 300 consecutive hits → `hit_count` saturates at 8'hFF.
